// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding imem request, single-entry instruction hold register.
// Optional performance counters are built only when IFU_PERF_EN is defined.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        imem_rsp_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        instD_valid,
  input  logic        instD_ready,
  output logic [31:0] instD,
  output logic [31:0] pcD,
  output logic [31:0] snpcD,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [11:0] funct12,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_wait_cnt
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALTED} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        drop, drop_n;
  logic        cap;
  logic        req_fire, inst_fire;

  assign imem_req_valid = (state == S_REQ) && !halt;
  assign imem_addr      = pc;
  // HALTED keeps draining so a response already in flight never stalls memory
  assign imem_rsp_ready = (state == S_WAIT) || (state == S_HALTED);
  assign instD_valid    = (state == S_HOLD);
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign inst_fire      = instD_valid && instD_ready;

  assign snpcD   = pcD + 32'd4;
  assign opcode  = instD[6:0];
  assign funct3  = instD[14:12];
  assign funct7  = instD[31:25];
  assign funct12 = instD[31:20];

  always_comb begin
    state_n = state;
    pc_n    = pc;
    drop_n  = drop;
    cap     = 1'b0;
    case (state)
      S_REQ: begin
        if (halt) state_n = S_HALTED;
        else begin
          if (req_fire) state_n = S_WAIT;
          if (redirect_valid) begin
            pc_n = redirect_pc;
            // request already accepted: its response belongs to the old path
            if (req_fire) drop_n = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (halt) state_n = S_HALTED;
        else if (redirect_valid) begin
          pc_n = redirect_pc;
          if (imem_rsp_valid) begin
            drop_n  = 1'b0;
            state_n = S_REQ;
          end else drop_n = 1'b1;
        end else if (imem_rsp_valid) begin
          if (drop) begin
            drop_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            cap     = 1'b1;
            state_n = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (halt) state_n = S_HALTED;
        else if (redirect_valid) begin
          pc_n    = redirect_pc;
          state_n = S_REQ;
        end else if (instD_ready) begin
          pc_n    = pc + 32'd4;
          state_n = S_REQ;
        end
      end
      default: state_n = S_HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      drop  <= 1'b0;
      instD <= 32'h0000_0013;
      pcD   <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      drop  <= drop_n;
      if (cap) begin
        instD <= imem_rsp_data;
        pcD   <= pc;
      end
    end
  end

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= 32'd0;
      perf_wait_cnt  <= 32'd0;
    end else begin
      if (inst_fire)         perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (state == S_WAIT)   perf_wait_cnt  <= perf_wait_cnt + 32'd1;
    end
  end
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_wait_cnt  = 32'd0;
  logic unused_perf;
  assign unused_perf = inst_fire;
`endif

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: bench plays imem and decode cycle by cycle, expected values hand-computed.
module tb_ifu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid, imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid, halt;
  logic [31:0] redirect_pc;
  logic        instD_valid, instD_ready;
  logic [31:0] instD, pcD, snpcD;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [11:0] funct12;
  logic [31:0] perf_fetch_cnt, perf_wait_cnt;

  int total = 0;
  int bad   = 0;

  ifu dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_ready(imem_rsp_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .instD_valid(instD_valid), .instD_ready(instD_ready),
    .instD(instD), .pcD(pcD), .snpcD(snpcD),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .funct12(funct12),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_wait_cnt(perf_wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs are driven and outputs sampled 2 time units after the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [31:0] exp_fetch, exp_wait;
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; instD_ready = 1'b0;
    #12;
    chk("rst_rsp_ready", imem_rsp_ready, 0);
    chk("rst_instD_valid", instD_valid, 0);
    chk("rst_instD", instD, 32'h0000_0013);
    chk("rst_pcD", pcD, 32'h8000_0000);
    chk("rst_snpcD", snpcD, 32'h8000_0004);
    chk("rst_perf_fetch", perf_fetch_cnt, 0);
    chk("rst_perf_wait", perf_wait_cnt, 0);
    rst_n = 1'b1;
    settle();
    chk("req_valid_after_rst", imem_req_valid, 1);
    chk("addr_after_rst", imem_addr, 32'h8000_0000);

    // basic fetch: handshake, response next cycle, delivered
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0;
    chk("wait_rsp_ready", imem_rsp_ready, 1);
    chk("wait_req_valid", imem_req_valid, 0);
    chk("wait_instD_valid", instD_valid, 0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093; tick();
    imem_rsp_valid = 1'b0;
    chk("hold_instD_valid", instD_valid, 1);
    chk("hold_instD", instD, 32'h0010_0093);
    chk("hold_opcode", {25'd0, opcode}, 32'h13);
    chk("hold_funct3", {29'd0, funct3}, 0);
    chk("hold_funct7", {25'd0, funct7}, 0);
    chk("hold_funct12", {20'd0, funct12}, 32'h001);
    chk("hold_pcD", pcD, 32'h8000_0000);
    chk("hold_snpcD", snpcD, 32'h8000_0004);

    // decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_instD_valid", instD_valid, 1);
      chk("stall_instD", instD, 32'h0010_0093);
      chk("stall_pcD", pcD, 32'h8000_0000);
      chk("stall_no_req", imem_req_valid, 0);
    end
    instD_ready = 1'b1; tick();
    instD_ready = 1'b0;
    chk("next_addr", imem_addr, 32'h8000_0004);
    chk("next_req_valid", imem_req_valid, 1);
    chk("next_instD_valid", instD_valid, 0);

    // redirect while waiting: response dropped
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100; tick();
    redirect_valid = 1'b0;
    chk("drop_still_wait", imem_rsp_ready, 1);
    chk("drop_no_req", imem_req_valid, 0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; tick();
    imem_rsp_valid = 1'b0;
    chk("drop_addr", imem_addr, 32'h8000_0100);
    chk("drop_req_valid", imem_req_valid, 1);
    chk("drop_instD_valid", instD_valid, 0);
    chk("drop_instD_kept", instD, 32'h0010_0093);

    // pc wrap at 2^32
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; tick();
    redirect_valid = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0513; tick();
    imem_rsp_valid = 1'b0;
    chk("wrap_pcD", pcD, 32'hFFFF_FFFC);
    chk("wrap_snpcD", snpcD, 32'h0000_0000);
    chk("wrap_instD", instD, 32'h0000_0513);
    instD_ready = 1'b1; tick();
    instD_ready = 1'b0;
    chk("wrap_next_addr", imem_addr, 32'h0000_0000);

    // redirect in HOLD without handshake kills the instruction
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00A0_0113; tick();
    imem_rsp_valid = 1'b0;
    chk("kill_hold", instD_valid, 1);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; tick();
    redirect_valid = 1'b0;
    chk("kill_instD_valid", instD_valid, 0);
    chk("kill_addr", imem_addr, 32'h8000_0200);

    // redirect on the request handshake cycle drops the response
    imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0300; tick();
    imem_req_ready = 1'b0; redirect_valid = 1'b0;
    chk("reqdrop_wait", imem_rsp_ready, 1);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0; tick();
    imem_rsp_valid = 1'b0;
    chk("reqdrop_addr", imem_addr, 32'h8000_0300);
    chk("reqdrop_instD_valid", instD_valid, 0);
    chk("reqdrop_instD", instD, 32'h00A0_0113);

    // redirect and delivery in the same cycle: redirect target wins
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0033; tick();
    imem_rsp_valid = 1'b0;
    chk("both_pcD", pcD, 32'h8000_0300);
    instD_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0400; tick();
    instD_ready = 1'b0; redirect_valid = 1'b0;
    chk("both_addr", imem_addr, 32'h8000_0400);

    // halt beats redirect; sticky until reset
    halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0500; imem_req_ready = 1'b1;
    settle();
    chk("halt_req_same_cycle", imem_req_valid, 0);
    tick();
    halt = 1'b0; redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("halted_req_valid", imem_req_valid, 0);
      chk("halted_instD_valid", instD_valid, 0);
      chk("halted_rsp_ready", imem_rsp_ready, 1);
      tick();
    end
    imem_req_ready = 1'b0;
    rst_n = 1'b0; settle();
    chk("rst2_instD", instD, 32'h0000_0013);
    rst_n = 1'b1; settle();
    chk("rst2_req_valid", imem_req_valid, 1);
    chk("rst2_addr", imem_addr, 32'h8000_0000);

    // 10 deliveries with a 2-cycle response delay
    for (int i = 0; i < 10; i++) begin
      imem_req_ready = 1'b1; tick();
      imem_req_ready = 1'b0; tick();
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013 + (i << 7); tick();
      imem_rsp_valid = 1'b0;
      chk("loop_pcD", pcD, 32'h8000_0000 + 32'(i * 4));
      chk("loop_instD", instD, 32'h0000_0013 + 32'(i << 7));
      instD_ready = 1'b1; tick();
      instD_ready = 1'b0;
    end
`ifdef IFU_PERF_EN
    exp_fetch = 32'd10; exp_wait = 32'd20;
`else
    exp_fetch = 32'd0;  exp_wait = 32'd0;
`endif
    chk("perf_fetch", perf_fetch_cnt, exp_fetch);
    chk("perf_wait", perf_wait_cnt, exp_wait);
    chk("loop_end_addr", imem_addr, 32'h8000_0028);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
